// File: rtl/card_pkg.sv
// Shared types and constants for the memory-card game controller.
package card_pkg;

   localparam int NUM_CARDS = 12;

   typedef enum logic [2:0] {
      IDLE,
      PICK1,
      PICK2,
      CHK_M,
      HOLD,
      CHK_F,
      WON
   } state_t;

   localparam logic [2:0] LVL1 = 3'b001;
   localparam logic [2:0] LVL2 = 3'b010;
   localparam logic [2:0] LVL3 = 3'b100;

   localparam logic [3:0] K_Q = 4'd0;
   localparam logic [3:0] K_W = 4'd1;
   localparam logic [3:0] K_E = 4'd2;
   localparam logic [3:0] K_R = 4'd3;
   localparam logic [3:0] K_A = 4'd4;
   localparam logic [3:0] K_S = 4'd5;
   localparam logic [3:0] K_D = 4'd6;
   localparam logic [3:0] K_F = 4'd7;
   localparam logic [3:0] K_Z = 4'd8;
   localparam logic [3:0] K_X = 4'd9;
   localparam logic [3:0] K_C = 4'd10;
   localparam logic [3:0] K_V = 4'd11;

   localparam logic [1:0] V_NONE = 2'd0;
   localparam logic [1:0] V_YES  = 2'd1;
   localparam logic [1:0] V_NO   = 2'd2;

   // Cards in play for each board size; row q..r is bits 0..3, a..f 4..7, z..v 8..11.
   function automatic logic [NUM_CARDS-1:0] level_mask(input logic [2:0] lvl);
      logic [NUM_CARDS-1:0] m;
      m = '0;
      case (lvl)
         LVL1: begin
            m[K_Q] = 1'b1; m[K_W] = 1'b1;
            m[K_A] = 1'b1; m[K_S] = 1'b1;
         end
         LVL2: begin
            m[K_Q] = 1'b1; m[K_W] = 1'b1; m[K_E] = 1'b1;
            m[K_A] = 1'b1; m[K_S] = 1'b1; m[K_D] = 1'b1;
         end
         LVL3:    m = '1;
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/card_key_arbiter.sv
// Lowest-index priority encoder over the eligible key requests.
module card_key_arbiter
   import card_pkg::*;
(
   input  logic [NUM_CARDS-1:0] req,
   output logic                 valid,
   output logic [3:0]           idx
);

   always_comb begin
      // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
      valid = 1'b0;
      idx   = '0;
      // Scan from the top down so the lowest requesting index is the last write.
      for (int i = NUM_CARDS - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = 4'(i);
         end
      end
   end

endmodule

// File: rtl/card_game_ctrl.sv
// Game-control FSM: key pulses to reveal flags, pair sequencing, match/finish
// handshakes with the display stage, mismatch hold timer and move counter.
module card_game_ctrl
   import card_pkg::*;
#(
   parameter int HOLD_CYCLES = 25000000,
   parameter int HOLD_W      = 25
)(
   input  logic        clk,
   input  logic        resetn,
   input  logic [2:0]  level,
   input  logic [11:0] key_pulse,
   input  logic [1:0]  is_correct,
   input  logic [1:0]  is_finished,
   output logic [11:0] reveal,
   output logic        check_match,
   output logic        check_finish,
   output logic        game_won,
   output logic [7:0]  moves
);

   state_t              state;
   logic [2:0]          level_q;
   logic [3:0]          idx_a;
   logic [3:0]          idx_b;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [11:0]         mask;
   logic [11:0]         key_req;
   logic                picking;
   logic                key_valid;
   logic [3:0]          key_idx;

   assign mask    = level_mask(level_q);
   assign picking = (state == PICK1) || (state == PICK2);
   assign key_req = key_pulse & mask & ~reveal & {12{picking}};

   card_key_arbiter u_arbiter (
      .req   (key_req),
      .valid (key_valid),
      .idx   (key_idx)
   );

   always_ff @(posedge clk) begin
      // NOTE: all state updates are non-blocking so every branch reads pre-edge values.
      if (!resetn || (level != level_q)) begin
         // A level change is a restart that also adopts the new board size.
         state        <= (resetn && (level_mask(level) != '0)) ? PICK1 : IDLE;
         level_q      <= level;
         reveal       <= '0;
         check_match  <= 1'b0;
         check_finish <= 1'b0;
         game_won     <= 1'b0;
         moves        <= '0;
         hold_cnt     <= '0;
         idx_a        <= '0;
         idx_b        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mask != '0) state <= PICK1;
            end
            PICK1: begin
               if (key_valid) begin
                  reveal[key_idx] <= 1'b1;
                  idx_a           <= key_idx;
                  state           <= PICK2;
               end
            end
            PICK2: begin
               if (key_valid) begin
                  reveal[key_idx] <= 1'b1;
                  idx_b           <= key_idx;
                  moves           <= (moves == 8'hFF) ? moves : moves + 8'd1;
                  check_match     <= 1'b1;
                  state           <= CHK_M;
               end
            end
            CHK_M: begin
               if (is_correct == V_YES) begin
                  check_match  <= 1'b0;
                  check_finish <= 1'b1;
                  state        <= CHK_F;
               end else if (is_correct == V_NO) begin
                  check_match <= 1'b0;
                  hold_cnt    <= HOLD_W'(HOLD_CYCLES - 1);
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (hold_cnt == '0) begin
                  reveal[idx_a] <= 1'b0;
                  reveal[idx_b] <= 1'b0;
                  state         <= PICK1;
               end else begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
            end
            CHK_F: begin
               if (is_finished == V_YES) begin
                  check_finish <= 1'b0;
                  game_won     <= 1'b1;
                  state        <= WON;
               end else if (is_finished == V_NO) begin
                  check_finish <= 1'b0;
                  state        <= PICK1;
               end
            end
            WON: begin
               state <= WON;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
